// File: rtl/div_unit.sv
// div_unit: multi-cycle radix-2 restoring divider for MIPS DIV/DIVU.
// Produces {remainder, quotient} for the HI/LO write path. A nonzero divisor
// gives ready WIDTH+1 cycles after acceptance; a zero divisor gives ready
// after 2 cycles with a zero result.
module div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               signed_div,
    input  logic               start,
    input  logic               annul,
    output logic [2*WIDTH-1:0] result,
    output logic               ready,
    output logic               stall
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DIVZERO = 2'd1,
        BUSY    = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg;
    logic [WIDTH-1:0]   rem_reg;    // partial remainder
    logic [WIDTH-1:0]   quo_reg;    // dividend bits shift out, quotient bits shift in
    logic [WIDTH-1:0]   dvs_reg;    // divisor magnitude
    logic               neg_q_reg;  // quotient must be negated at the end
    logic               neg_r_reg;  // remainder takes the dividend's sign
    logic [2*WIDTH-1:0] result_reg;

    logic               accept;
    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_abs, b_abs;
    logic [WIDTH:0]     rem_shift, diff;
    logic [WIDTH-1:0]   rem_next, quo_next, q_fix, r_fix;

    // Operand magnitudes; only signed divisions look at the sign bits.
    assign a_neg  = signed_div & a[WIDTH-1];
    assign b_neg  = signed_div & b[WIDTH-1];
    assign a_abs  = a_neg ? -a : a;
    assign b_abs  = b_neg ? -b : b;
    assign accept = (state_reg == IDLE) & start & ~annul;

    // One restoring step: shift {rem, dividend} left, trial-subtract with one
    // extra bit so the borrow shows up as the MSB of the difference.
    assign rem_shift = {rem_reg, quo_reg[WIDTH-1]};
    assign diff      = rem_shift - {1'b0, dvs_reg};
    assign rem_next  = diff[WIDTH] ? rem_shift[WIDTH-1:0] : diff[WIDTH-1:0];
    assign quo_next  = {quo_reg[WIDTH-2:0], ~diff[WIDTH]};

    // Sign correction applied to the final step's outputs; negation wraps, so
    // the most negative value divided by -1 returns itself.
    assign q_fix = neg_q_reg ? -quo_next : quo_next;
    assign r_fix = neg_r_reg ? -rem_next : rem_next;

    assign result = result_reg;
    assign ready  = (state_reg == DONE);
    assign stall  = start & ~ready;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; annul drops an in-flight division without a ready pulse.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    state_next = (b == '0) ? DIVZERO : BUSY;
                end
            end
            DIVZERO: begin
                state_next = annul ? IDLE : DONE;
            end
            BUSY: begin
                if (annul) begin
                    state_next = IDLE;
                end else if (cnt_reg == CNT_W'(WIDTH - 1)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath: capture operands on acceptance, iterate in BUSY, and register
    // the corrected result only on the edge that enters DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg    <= '0;
            rem_reg    <= '0;
            quo_reg    <= '0;
            dvs_reg    <= '0;
            neg_q_reg  <= 1'b0;
            neg_r_reg  <= 1'b0;
            result_reg <= '0;
        end else begin
            if (accept) begin
                neg_q_reg <= a_neg ^ b_neg;
                neg_r_reg <= a_neg;
                rem_reg   <= '0;
                quo_reg   <= a_abs;
                dvs_reg   <= b_abs;
                cnt_reg   <= '0;
            end else if (state_reg == BUSY) begin
                rem_reg <= rem_next;
                quo_reg <= quo_next;
                cnt_reg <= cnt_reg + 1'b1;
            end

            if (state_reg == BUSY && state_next == DONE) begin
                result_reg <= {r_fix, q_fix};
            end else if (state_reg == DIVZERO && state_next == DONE) begin
                result_reg <= '0;
            end
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed vectors for div_unit with hand-computed results,
// latencies and stall behaviour.
module tb_div_unit;

    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst, start, annul, signed_div;
    logic [W-1:0]   a, b;
    logic [2*W-1:0] result;
    logic           ready, stall;

    int             n_vec = 0;
    int             n_err = 0;
    int             extra_pulses = 0;
    int             pulses;
    logic [2*W-1:0] r0;

    always #5 clk = ~clk;

    div_unit #(.WIDTH(W), .CNT_W(6)) dut (
        .clk(clk), .rst(rst), .a(a), .b(b), .signed_div(signed_div),
        .start(start), .annul(annul), .result(result), .ready(ready), .stall(stall)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Start a division (start held through ready) and check latency, result
    // and stall. Returns the result seen in cycle 0. With scramble set, the
    // operands are replaced by junk from cycle 1 on.
    task automatic run_div(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb,
                           input logic tsd, input logic [2*W-1:0] exp_res, input int exp_lat,
                           input bit scramble, output logic [2*W-1:0] res_c0);
        int             rdy_cyc;
        int             stall_err;
        logic [2*W-1:0] res_seen;
        rdy_cyc   = -1;
        stall_err = 0;
        res_seen  = 'x;
        res_c0    = 'x;
        for (int c = 0; c <= exp_lat + 4 && rdy_cyc < 0; c++) begin
            @(posedge clk); #1;
            if (c == 0) begin
                a = ta; b = tb; signed_div = tsd; start = 1'b1; annul = 1'b0;
            end else if (scramble) begin
                a = $urandom; b = $urandom; signed_div = ~signed_div;
            end
            #1;
            if (c == 0) res_c0 = result;
            if (stall !== (c < exp_lat)) stall_err++;
            if (ready === 1'b1) begin
                rdy_cyc  = c;
                res_seen = result;
            end
        end
        $display("div %s a=%h b=%h s=%0d -> result=%h ready_cycle=%0d", tag, ta, tb, tsd, res_seen, rdy_cyc);
        check({tag, "_lat"}, 64'(rdy_cyc), 64'(exp_lat));
        check({tag, "_res"}, res_seen, exp_res);
        check({tag, "_stall"}, 64'(stall_err), 64'd0);
    endtask

    // Idle cycles with start low; any ready pulse here is spurious.
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            start = 1'b0; annul = 1'b0;
            #1;
            if (ready === 1'b1) extra_pulses++;
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; annul = 1'b0; signed_div = 1'b0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1; rst = 1'b0; #1;
        check("rst_result", result, 64'd0);
        check("rst_ready", 64'(ready), 64'd0);
        check("rst_stall", 64'(stall), 64'd0);

        run_div("u_100_7", 32'd100, 32'd7, 1'b0, {32'h2, 32'hE}, 33, 1'b0, r0); idle(1);
        run_div("s_m7_2", 32'hFFFFFFF9, 32'd2, 1'b1, {32'hFFFFFFFF, 32'hFFFFFFFD}, 33, 1'b0, r0); idle(2);
        run_div("u_m7_2", 32'hFFFFFFF9, 32'd2, 1'b0, {32'h1, 32'h7FFFFFFC}, 33, 1'b0, r0); idle(1);
        run_div("s_7_m2", 32'd7, 32'hFFFFFFFE, 1'b1, {32'h1, 32'hFFFFFFFD}, 33, 1'b0, r0); idle(1);
        run_div("s_min_m1", 32'h80000000, 32'hFFFFFFFF, 1'b1, {32'h0, 32'h80000000}, 33, 1'b0, r0); idle(1);
        run_div("u_max_1", 32'hFFFFFFFF, 32'd1, 1'b0, {32'h0, 32'hFFFFFFFF}, 33, 1'b0, r0); idle(1);
        run_div("u_5_max", 32'd5, 32'hFFFFFFFF, 1'b0, {32'h5, 32'h0}, 33, 1'b0, r0); idle(1);
        run_div("s_m100_7", 32'hFFFFFF9C, 32'd7, 1'b1, {32'hFFFFFFFE, 32'hFFFFFFF2}, 33, 1'b0, r0); idle(1);

        // Divide by zero, with operands trashed after acceptance.
        run_div("dz_123_0", 32'd123, 32'd0, 1'b0, 64'd0, 2, 1'b1, r0);
        check("dz_hold_prev", r0, {32'hFFFFFFFE, 32'hFFFFFFF2});
        idle(1);

        // Back-to-back: start stays high, second set accepted right after DONE.
        run_div("b2b_200_9", 32'd200, 32'd9, 1'b0, {32'h2, 32'h16}, 33, 1'b0, r0);
        run_div("b2b_81_4", 32'd81, 32'd4, 1'b0, {32'h1, 32'h14}, 33, 1'b0, r0);
        idle(2);

        // Annul in cycle 10, new start (9/3) in cycle 11 -> ready in cycle 44.
        @(posedge clk); #1;
        a = 32'd1000; b = 32'd3; signed_div = 1'b0; start = 1'b1; annul = 1'b0;
        pulses = 0;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk); #1;
            if (c == 10) annul = 1'b1;
            #1;
            if (ready === 1'b1) pulses++;
        end
        check("annul_no_ready", 64'(pulses), 64'd0);
        run_div("after_annul_9_3", 32'd9, 32'd3, 1'b0, {32'h0, 32'h3}, 33, 1'b0, r0);
        check("annul_hold_prev", r0, {32'h1, 32'h14});
        idle(1);

        // Reset in cycle 20 of a division; outputs all zero in cycle 21.
        @(posedge clk); #1;
        a = 32'd50; b = 32'd5; signed_div = 1'b0; start = 1'b1; annul = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            if (c == 20) begin
                rst = 1'b1; start = 1'b0;
            end
        end
        @(posedge clk); #1;
        rst = 1'b0; #1;
        $display("reset mid-division: result=%h ready=%0d stall=%0d", result, ready, stall);
        check("midrst_result", result, 64'd0);
        check("midrst_ready", 64'(ready), 64'd0);
        check("midrst_stall", 64'(stall), 64'd0);
        idle(1);
        run_div("after_rst_50_5", 32'd50, 32'd5, 1'b0, {32'h0, 32'hA}, 33, 1'b0, r0);
        idle(3);

        check("extra_ready_pulses", 64'(extra_pulses), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
